rob_mc: RTL and testbench
=========================

// Module: rob_mc
// PURPOSE
// Parametrised reorder buffer: in-order allocate from rename, out-of-order completion by tag, in-order commit of up to
// COMMIT_W entries/cycle to the RRAT. Sits between rename, exe/mem writeback, IF redirect and the RRAT.
// Recovers from branch mispredicts and syscalls by flushing all entries and redirecting IF.
// PARAMETERS
// DEPTH     64  entries, power of 2, >=4
// TAG_W     6   log2(DEPTH), entry tag width
// PREG_W    6   physical register index width
// CPL_N     2   completion ports (exe, mem, ...)
// COMMIT_W  2   max commits per cycle, 1..4
// PORTS
// clk           in   1              clock, all state on posedge
// reset         in   1              synchronous, active-high
// stall         in   1              freezes commit and redirect; enqueue and completion unaffected
// enq_valid     in   1              rename offers one instruction
// enq_ready     out  1              ROB can accept; equals (count < DEPTH) && !flush
// enq_regwr     in   1              instruction writes an arch register
// enq_areg      in   5              destination arch register
// enq_preg      in   PREG_W         new physical mapping
// enq_is_br     in   1              branch or jump
// enq_is_sys    in   1              syscall
// enq_pc        in   32             instruction PC
// enq_tag       out  TAG_W          tag assigned to the offered instruction (current tail)
// cpl_valid     in   CPL_N          per-port completion strobe
// cpl_tag       in   CPL_N*TAG_W    per-port completed tag
// cpl_mispred   in   CPL_N          branch resolved mispredicted
// cpl_alt_pc    in   CPL_N*32       correct target on mispredict
// head_tag      out  TAG_W          oldest entry tag (LSQ/HILO commit gating)
// head_valid    out  1              ROB non-empty
// cmt_valid     out  COMMIT_W       per-slot commit strobe, slot 0 oldest
// cmt_regwr     out  COMMIT_W       per-slot RRAT update enable
// cmt_areg      out  COMMIT_W*5     per-slot arch register
// cmt_preg      out  COMMIT_W*PREG_W per-slot physical register
// sys           out  1              a syscall committed this cycle
// flush         out  1              pipeline flush pulse
// redirect_pc   out  32             IF target, valid when flush=1
// BEHAVIOUR
// - Reset: head=tail=0, count=0, all valid/done bits 0; every output 0 except enq_ready=1.
// - Pointers TAG_W+1 bits; full = MSBs differ, low bits equal. Wrap DEPTH-1 -> 0 is transparent.
// - Enqueue: enq_valid && enq_ready writes entry at tail, done=0, mispred=0, tail++. enq_ready from registered count
//   only: at full, no same-cycle bypass even if commit frees slots.
// - Completion: port p writes done=1 at cpl_tag[p] only if entry valid; invalid tag ignored. mispred/alt_pc latched only
//   for is_br entries. Distinct tags on multiple ports all apply; equal tags: higher port index wins alt_pc.
//   Completion to the tail slot being enqueued the same cycle is ignored (illegal, not an error).
// - Commit (stall=0): slot k commits iff entries head..head+k all valid and done, and no earlier slot in the group
//   is a mispredicted branch or syscall. A mispredicted branch or syscall commits as the last slot of its group.
//   Outputs registered: strobes appear the cycle after the commit decision; head += number committed.
// - Syscall commit: sys=1, flush=1, redirect_pc=pc+4. Mispred commit: flush=1, redirect_pc=alt_pc.
//   Both: the committing entry's RRAT update is still issued.
// - Flush: on the decision cycle all entries invalidated, head=tail=0, count=0; enqueue that cycle dropped.
//   flush is a 1-cycle pulse; enq_ready=0 while flush=1; completions while flush=1 ignored.
// - count_next = count + enq_fire - n_commit (simultaneous legal); cleared on flush.
// - stall=1: no commit, cmt_valid=0, flush=0; pending done bits retained.
// - reset mid-operation overrides everything in the same edge.
// STRUCTURE
// - Shared package rob_pkg: rob_entry_t {valid, done, regwr, areg, preg, is_br, is_sys, mispred, pc, alt_pc},
//   ROB_DEPTH / COMMIT_W defaults, ptr_t.
// - One sub-module, rob_commit_sel: combinational COMMIT_W-wide in-order ready scan returning commit mask, count,
//   and terminating-slot index.
// TESTING
// - Reset, enqueue 3 (areg 1,2,3 / preg 33,34,35), complete tags 2,1,0 -> cycle after tag 0 done: cmt_valid=2'b11
//   (areg 1,2); next cycle cmt_valid=2'b01 (areg 3).
// - Fill 64 without completions -> enq_ready=0 at count 64; complete head and enq same cycle -> enq_ready=1 the
//   cycle after, tail wraps to 0, enq_tag=0.
// - Branch at tag 5 (pc 0x100), mispred, alt_pc 0x400, tags 6..9 done -> tag 5 is the last commit, flush=1,
//   redirect_pc=0x400, count=0 next cycle, tags 6..9 never commit.
// - Syscall pc 0x200 at head with done younger entry -> sys=1, flush=1, redirect_pc=0x204, younger entry dropped.
// - stall=1 for 3 cycles with 4 done entries -> no cmt_valid; stall release -> 2 commits/cycle over 2 cycles.
// - reset asserted with 10 live entries and a pending mispred -> next cycle all outputs 0, enq_ready=1, no flush.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and defaults for the reorder buffer: entry layout, pointer type and
// default geometry used by rob_mc and rob_commit_sel.
package rob_pkg;
  localparam int ROB_DEPTH    = 64;
  localparam int ROB_TAG_W    = 6;
  localparam int ROB_PREG_W   = 6;
  localparam int ROB_COMMIT_W = 2;

  // One extra bit over the index distinguishes full from empty
  typedef logic [ROB_TAG_W:0] ptr_t;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  regwr;
    logic [4:0]            areg;
    logic [ROB_PREG_W-1:0] preg;
    logic                  is_br;
    logic                  is_sys;
    logic                  mispred;
    logic [31:0]           pc;
    logic [31:0]           alt_pc;
  } rob_entry_t;
endpackage

// File: rtl/rob_commit_sel.sv
// In-order commit scan over the oldest COMMIT_W entries: returns the commit mask, the
// number committed and the index of the last committing slot (flagged if it ends the group).
module rob_commit_sel #(
  parameter int COMMIT_W = 2,
  parameter int CNT_W    = $clog2(COMMIT_W + 1),
  parameter int IDX_W    = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1
) (
  input  logic [COMMIT_W-1:0] slot_rdy,
  input  logic [COMMIT_W-1:0] slot_stop,
  output logic [COMMIT_W-1:0] mask,
  output logic [CNT_W-1:0]    n_cmt,
  output logic                term,
  output logic [IDX_W-1:0]    last_idx
);

  logic open_s;

  // Scan oldest-first; a not-ready slot or a redirecting slot closes the group
  always_comb begin
    mask     = '0;
    n_cmt    = '0;
    term     = 1'b0;
    last_idx = '0;
    open_s   = 1'b1;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (open_s && slot_rdy[k]) begin
        mask[k]  = 1'b1;
        n_cmt    = n_cmt + CNT_W'(1'b1);
        term     = slot_stop[k];
        last_idx = IDX_W'(k);
        open_s   = !slot_stop[k];
      end else begin
        open_s = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_mc.sv
// Reorder buffer: in-order allocate, out-of-order completion by tag, in-order commit of
// up to COMMIT_W entries per cycle, with full flush and IF redirect on mispredict/syscall.
module rob_mc
  import rob_pkg::*;
#(
  parameter int DEPTH    = ROB_DEPTH,
  parameter int TAG_W    = ROB_TAG_W,
  parameter int PREG_W   = ROB_PREG_W,
  parameter int CPL_N    = 2,
  parameter int COMMIT_W = ROB_COMMIT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic                       enq_regwr,
  input  logic [4:0]                 enq_areg,
  input  logic [PREG_W-1:0]          enq_preg,
  input  logic                       enq_is_br,
  input  logic                       enq_is_sys,
  input  logic [31:0]                enq_pc,
  output logic [TAG_W-1:0]           enq_tag,
  input  logic [CPL_N-1:0]           cpl_valid,
  input  logic [CPL_N*TAG_W-1:0]     cpl_tag,
  input  logic [CPL_N-1:0]           cpl_mispred,
  input  logic [CPL_N*32-1:0]        cpl_alt_pc,
  output logic [TAG_W-1:0]           head_tag,
  output logic                       head_valid,
  output logic [COMMIT_W-1:0]        cmt_valid,
  output logic [COMMIT_W-1:0]        cmt_regwr,
  output logic [COMMIT_W*5-1:0]      cmt_areg,
  output logic [COMMIT_W*PREG_W-1:0] cmt_preg,
  output logic                       sys,
  output logic                       flush,
  output logic [31:0]                redirect_pc
);

  localparam int CNT_W = $clog2(COMMIT_W + 1);
  localparam int IDX_W = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;
  localparam logic [TAG_W:0] DEPTH_C = (TAG_W + 1)'(DEPTH);

  rob_entry_t       rob_r [DEPTH];
  logic [TAG_W:0]   head_r;
  logic [TAG_W:0]   tail_r;
  logic [TAG_W:0]   count_r;

  logic [TAG_W-1:0] head_idx_s;
  logic [TAG_W-1:0] tail_idx_s;
  logic             enq_fire_s;

  logic [TAG_W-1:0] slot_idx_s [COMMIT_W];
  rob_entry_t       slot_e_s   [COMMIT_W];
  logic [COMMIT_W-1:0] slot_rdy_s;
  logic [COMMIT_W-1:0] slot_stop_s;

  logic [COMMIT_W-1:0] sel_mask_s;
  logic [CNT_W-1:0]    sel_n_s;
  logic                sel_term_s;
  logic [IDX_W-1:0]    sel_last_s;

  logic [COMMIT_W-1:0] mask_s;
  logic [CNT_W-1:0]    n_s;
  logic                flush_dec_s;
  logic                sys_dec_s;
  rob_entry_t          term_e_s;
  logic [31:0]         target_s;

  logic [TAG_W-1:0]    cpl_idx_s [CPL_N];
  logic [CPL_N-1:0]    cpl_ok_s;

  assign head_idx_s = head_r[TAG_W-1:0];
  assign tail_idx_s = tail_r[TAG_W-1:0];

  // Readiness comes from registered state only, so a commit never frees a slot for the same edge
  assign enq_ready  = (count_r != DEPTH_C) && !flush;
  assign enq_fire_s = enq_valid && enq_ready;
  assign enq_tag    = tail_idx_s;
  assign head_tag   = head_idx_s;
  assign head_valid = (count_r != '0);

  for (genvar k = 0; k < COMMIT_W; k++) begin : g_slot
    assign slot_idx_s[k]  = head_idx_s + TAG_W'(k);
    assign slot_e_s[k]    = rob_r[slot_idx_s[k]];
    assign slot_rdy_s[k]  = slot_e_s[k].valid && slot_e_s[k].done;
    assign slot_stop_s[k] = slot_e_s[k].is_sys || (slot_e_s[k].is_br && slot_e_s[k].mispred);
  end

  rob_commit_sel #(
    .COMMIT_W (COMMIT_W)
  ) u_commit_sel (
    .slot_rdy  (slot_rdy_s),
    .slot_stop (slot_stop_s),
    .mask      (sel_mask_s),
    .n_cmt     (sel_n_s),
    .term      (sel_term_s),
    .last_idx  (sel_last_s)
  );

  assign mask_s      = stall ? '0 : sel_mask_s;
  assign n_s         = stall ? '0 : sel_n_s;
  assign flush_dec_s = !stall && sel_term_s;
  assign term_e_s    = slot_e_s[sel_last_s];
  assign sys_dec_s   = flush_dec_s && term_e_s.is_sys;
  assign target_s    = term_e_s.is_sys ? (term_e_s.pc + 32'd4) : term_e_s.alt_pc;

  // A completion landing on the slot being allocated this cycle is dropped
  for (genvar p = 0; p < CPL_N; p++) begin : g_cpl
    assign cpl_idx_s[p] = cpl_tag[p*TAG_W +: TAG_W];
    assign cpl_ok_s[p]  = cpl_valid[p] && !flush && rob_r[cpl_idx_s[p]].valid &&
                          !(enq_fire_s && (cpl_idx_s[p] == tail_idx_s));
  end

  // Entry array and pointers: reset, then flush, else completion, commit retire and allocate
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rob_r[i] <= '0;
      end
    end else if (flush_dec_s) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rob_r[i].valid   <= 1'b0;
        rob_r[i].done    <= 1'b0;
        rob_r[i].mispred <= 1'b0;
      end
    end else begin
      // Later ports are written last, so the highest index wins on equal tags
      for (int p = 0; p < CPL_N; p++) begin
        if (cpl_ok_s[p]) begin
          rob_r[cpl_idx_s[p]].done <= 1'b1;
          if (rob_r[cpl_idx_s[p]].is_br) begin
            rob_r[cpl_idx_s[p]].mispred <= cpl_mispred[p];
            rob_r[cpl_idx_s[p]].alt_pc  <= cpl_alt_pc[p*32 +: 32];
          end
        end
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        if (mask_s[k]) begin
          rob_r[slot_idx_s[k]].valid <= 1'b0;
        end
      end
      if (enq_fire_s) begin
        rob_r[tail_idx_s] <= '{valid: 1'b1, done: 1'b0, regwr: enq_regwr, areg: enq_areg,
                               preg: enq_preg, is_br: enq_is_br, is_sys: enq_is_sys,
                               mispred: 1'b0, pc: enq_pc, alt_pc: 32'h0};
      end
      head_r  <= head_r + {{(TAG_W + 1 - CNT_W){1'b0}}, n_s};
      tail_r  <= tail_r + {{TAG_W{1'b0}}, enq_fire_s};
      count_r <= count_r + {{TAG_W{1'b0}}, enq_fire_s} - {{(TAG_W + 1 - CNT_W){1'b0}}, n_s};
    end
  end

  // Registered commit strobes, RRAT update fields and the redirect pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      cmt_valid   <= '0;
      cmt_regwr   <= '0;
      cmt_areg    <= '0;
      cmt_preg    <= '0;
      sys         <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= 32'h0;
    end else begin
      cmt_valid <= mask_s;
      for (int k = 0; k < COMMIT_W; k++) begin
        cmt_regwr[k]              <= mask_s[k] && slot_e_s[k].regwr;
        cmt_areg[k*5 +: 5]        <= mask_s[k] ? slot_e_s[k].areg : 5'd0;
        cmt_preg[k*PREG_W +: PREG_W] <= mask_s[k] ? slot_e_s[k].preg : {PREG_W{1'b0}};
      end
      sys         <= sys_dec_s;
      flush       <= flush_dec_s;
      redirect_pc <= flush_dec_s ? target_s : 32'h0;
    end
  end

endmodule

// File: tb/tb_rob_mc.sv
// Scoreboard bench for rob_mc: directed stimulus pushes hand-computed commit groups,
// a negedge monitor pops and compares them whenever the ROB commits or flushes.
module tb_rob_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        enq_valid;
  logic        enq_ready;
  logic        enq_regwr;
  logic [4:0]  enq_areg;
  logic [5:0]  enq_preg;
  logic        enq_is_br;
  logic        enq_is_sys;
  logic [31:0] enq_pc;
  logic [5:0]  enq_tag;
  logic [1:0]  cpl_valid;
  logic [11:0] cpl_tag;
  logic [1:0]  cpl_mispred;
  logic [63:0] cpl_alt_pc;
  logic [5:0]  head_tag;
  logic        head_valid;
  logic [1:0]  cmt_valid;
  logic [1:0]  cmt_regwr;
  logic [9:0]  cmt_areg;
  logic [11:0] cmt_preg;
  logic        sys;
  logic        flush;
  logic [31:0] redirect_pc;

  rob_mc dut (
    .clk(clk), .reset(reset), .stall(stall),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_regwr(enq_regwr),
    .enq_areg(enq_areg), .enq_preg(enq_preg), .enq_is_br(enq_is_br),
    .enq_is_sys(enq_is_sys), .enq_pc(enq_pc), .enq_tag(enq_tag),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_mispred(cpl_mispred),
    .cpl_alt_pc(cpl_alt_pc), .head_tag(head_tag), .head_valid(head_valid),
    .cmt_valid(cmt_valid), .cmt_regwr(cmt_regwr), .cmt_areg(cmt_areg),
    .cmt_preg(cmt_preg), .sys(sys), .flush(flush), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  typedef struct {
    logic [31:0]     cyc;
    logic [1:0]      valid;
    logic [1:0]      regwr;
    logic [1:0][4:0] areg;
    logic [1:0][5:0] preg;
    logic            sys;
    logic            flush;
    logic [31:0]     rpc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_c;
  logic [31:0] c0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic expect_cmt(input logic [31:0] c, input logic [1:0] v, input logic [1:0] rw,
                            input logic [4:0] a0, input logic [5:0] p0,
                            input logic [4:0] a1, input logic [5:0] p1,
                            input logic sy, input logic fl, input logic [31:0] rpc);
    exp_t e;
    e.cyc = c; e.valid = v; e.regwr = rw;
    e.areg[0] = a0; e.preg[0] = p0; e.areg[1] = a1; e.preg[1] = p1;
    e.sys = sy; e.flush = fl; e.rpc = rpc;
    exp_q.push_back(e);
  endtask

  // Monitor: any non-idle commit/flush cycle must match the oldest expected group
  always @(negedge clk) begin
    if (!reset && (cmt_valid != 2'b00 || flush || sys)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit cyc=%0d cmt_valid=%b flush=%b sys=%b areg=%h",
                 cyc, cmt_valid, flush, sys, cmt_areg);
      end else begin
        mon_e = exp_q.pop_front();
        chk("cmt_cycle", cyc, mon_e.cyc);
        chk("cmt_valid", 32'(cmt_valid), 32'(mon_e.valid));
        for (int s = 0; s < 2; s++) begin
          if (mon_e.valid[s]) begin
            chk("cmt_regwr", 32'(cmt_regwr[s]), 32'(mon_e.regwr[s]));
            chk("cmt_areg", 32'(cmt_areg[s*5 +: 5]), 32'(mon_e.areg[s]));
            chk("cmt_preg", 32'(cmt_preg[s*6 +: 6]), 32'(mon_e.preg[s]));
          end
        end
        chk("sys", 32'(sys), 32'(mon_e.sys));
        chk("flush", 32'(flush), 32'(mon_e.flush));
        if (mon_e.flush) chk("redirect_pc", redirect_pc, mon_e.rpc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; enq_valid = 1'b0; enq_regwr = 1'b0; enq_areg = 5'd0; enq_preg = 6'd0;
    enq_is_br = 1'b0; enq_is_sys = 1'b0; enq_pc = 32'h0;
    cpl_valid = 2'b00; cpl_tag = 12'h0; cpl_mispred = 2'b00; cpl_alt_pc = 64'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic enq(input logic [5:0] etag, input logic rw, input logic [4:0] a,
                     input logic [5:0] p, input logic br, input logic sy, input logic [31:0] pc);
    chk("enq_ready", 32'(enq_ready), 32'd1);
    chk("enq_tag", 32'(enq_tag), 32'(etag));
    enq_valid = 1'b1; enq_regwr = rw; enq_areg = a; enq_preg = p;
    enq_is_br = br; enq_is_sys = sy; enq_pc = pc;
    step();
    enq_valid = 1'b0;
  endtask

  task automatic cpl(input logic v0, input logic [5:0] t0, input logic m0, input logic [31:0] a0,
                     input logic v1, input logic [5:0] t1, input logic m1, input logic [31:0] a1);
    cpl_valid = {v1, v0}; cpl_tag = {t1, t0}; cpl_mispred = {m1, m0}; cpl_alt_pc = {a1, a0};
    last_c = cyc;
    step();
    cpl_valid = 2'b00;
  endtask

  task automatic chk_idle_outputs(input string tagname);
    chk({tagname, "_cmt_valid"}, 32'(cmt_valid), 32'd0);
    chk({tagname, "_cmt_regwr"}, 32'(cmt_regwr), 32'd0);
    chk({tagname, "_cmt_areg"}, 32'(cmt_areg), 32'd0);
    chk({tagname, "_cmt_preg"}, 32'(cmt_preg), 32'd0);
    chk({tagname, "_sys"}, 32'(sys), 32'd0);
    chk({tagname, "_flush"}, 32'(flush), 32'd0);
    chk({tagname, "_redirect"}, redirect_pc, 32'd0);
    chk({tagname, "_enq_ready"}, 32'(enq_ready), 32'd1);
    chk({tagname, "_head_valid"}, 32'(head_valid), 32'd0);
    chk({tagname, "_enq_tag"}, 32'(enq_tag), 32'd0);
    chk({tagname, "_head_tag"}, 32'(head_tag), 32'd0);
  endtask

  initial begin
    #100000;
    checks++;
    errors++;
    $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("reset");

    // Three in order, completed in reverse: 2-wide then 1-wide commit
    enq(6'd0, 1'b1, 5'd1, 6'd33, 1'b0, 1'b0, 32'h0);
    enq(6'd1, 1'b1, 5'd2, 6'd34, 1'b0, 1'b0, 32'h4);
    enq(6'd2, 1'b1, 5'd3, 6'd35, 1'b0, 1'b0, 32'h8);
    chk("head_valid_live", 32'(head_valid), 32'd1);
    cpl(1'b1, 6'd2, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 32'h0);
    cpl(1'b1, 6'd1, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 32'h0);
    cpl(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 32'h0);
    expect_cmt(last_c + 32'd2, 2'b11, 2'b11, 5'd1, 6'd33, 5'd2, 6'd34, 1'b0, 1'b0, 32'h0);
    expect_cmt(last_c + 32'd3, 2'b01, 2'b01, 5'd3, 6'd35, 5'd0, 6'd0, 1'b0, 1'b0, 32'h0);
    repeat (4) step();
    chk("drained_head_valid", 32'(head_valid), 32'd0);
    chk("drained_enq_tag", 32'(enq_tag), 32'd3);
    chk("drained_head_tag", 32'(head_tag), 32'd3);

    // Fill all 64 slots, then free the head while offering a new entry
    do_reset();
    for (int i = 0; i < 64; i++) begin
      enq(6'(i), 1'b1, 5'((i % 31) + 1), 6'(i), 1'b0, 1'b0, 32'(i * 4));
    end
    chk("full_enq_ready", 32'(enq_ready), 32'd0);
    chk("full_enq_tag", 32'(enq_tag), 32'd0);
    chk("full_head_valid", 32'(head_valid), 32'd1);
    cpl_valid = 2'b01; cpl_tag = 12'h0; cpl_mispred = 2'b00;
    enq_valid = 1'b1; enq_regwr = 1'b1; enq_areg = 5'd7; enq_preg = 6'd60; enq_pc = 32'h1000;
    c0 = cyc;
    @(negedge clk);
    chk("full_no_bypass_a", 32'(enq_ready), 32'd0);
    step();
    cpl_valid = 2'b00;
    @(negedge clk);
    chk("full_no_bypass_b", 32'(enq_ready), 32'd0);
    expect_cmt(c0 + 32'd2, 2'b01, 2'b01, 5'd1, 6'd0, 5'd0, 6'd0, 1'b0, 1'b0, 32'h0);
    step();
    @(negedge clk);
    chk("ready_after_commit", 32'(enq_ready), 32'd1);
    chk("tail_wrap_tag", 32'(enq_tag), 32'd0);
    chk("head_after_commit", 32'(head_tag), 32'd1);
    step();
    enq_valid = 1'b0;
    chk("tail_after_wrap", 32'(enq_tag), 32'd1);
    chk("refull_enq_ready", 32'(enq_ready), 32'd0);

    // Mispredicted branch at tag 5; equal-tag completion, port 1 alt_pc wins
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) enq(6'd5, 1'b1, 5'd31, 6'd50, 1'b1, 1'b0, 32'h100);
      else        enq(6'(i), 1'b1, 5'(i + 10), 6'(i + 20), 1'b0, 1'b0, 32'(i * 4));
    end
    cpl(1'b1, 6'd6, 1'b0, 32'h0, 1'b1, 6'd7, 1'b0, 32'h0);
    cpl(1'b1, 6'd8, 1'b0, 32'h0, 1'b1, 6'd9, 1'b0, 32'h0);
    cpl(1'b1, 6'd5, 1'b1, 32'h300, 1'b1, 6'd5, 1'b1, 32'h400);
    cpl(1'b1, 6'd0, 1'b0, 32'h0, 1'b1, 6'd1, 1'b0, 32'h0);
    expect_cmt(last_c + 32'd2, 2'b11, 2'b11, 5'd10, 6'd20, 5'd11, 6'd21, 1'b0, 1'b0, 32'h0);
    cpl(1'b1, 6'd2, 1'b0, 32'h0, 1'b1, 6'd3, 1'b0, 32'h0);
    expect_cmt(last_c + 32'd2, 2'b11, 2'b11, 5'd12, 6'd22, 5'd13, 6'd23, 1'b0, 1'b0, 32'h0);
    cpl(1'b1, 6'd4, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 32'h0);
    expect_cmt(last_c + 32'd2, 2'b11, 2'b11, 5'd14, 6'd24, 5'd31, 6'd50, 1'b0, 1'b1, 32'h400);
    step();
    @(negedge clk);
    chk("flush_enq_ready", 32'(enq_ready), 32'd0);
    chk("flush_head_valid", 32'(head_valid), 32'd0);
    step();
    @(negedge clk);
    chk("post_flush_enq_ready", 32'(enq_ready), 32'd1);
    chk("post_flush_enq_tag", 32'(enq_tag), 32'd0);
    chk("post_flush_head_valid", 32'(head_valid), 32'd0);
    repeat (3) step();

    // Syscall at head with a done younger entry behind it
    do_reset();
    enq(6'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1, 32'h200);
    enq(6'd1, 1'b1, 5'd5, 6'd9, 1'b0, 1'b0, 32'h204);
    cpl(1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 6'd1, 1'b0, 32'h0);
    cpl(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 32'h0);
    expect_cmt(last_c + 32'd2, 2'b01, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b1, 1'b1, 32'h204);
    repeat (2) step();
    chk("sys_dropped_head_valid", 32'(head_valid), 32'd0);
    chk("sys_enq_tag", 32'(enq_tag), 32'd0);
    repeat (3) step();

    // Stall holds four done entries, release drains two per cycle
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enq(6'(i), 1'b1, 5'(i + 1), 6'(i + 40), 1'b0, 1'b0, 32'(i * 4));
    end
    cpl(1'b1, 6'd0, 1'b0, 32'h0, 1'b1, 6'd1, 1'b0, 32'h0);
    cpl(1'b1, 6'd2, 1'b0, 32'h0, 1'b1, 6'd3, 1'b0, 32'h0);
    repeat (3) step();
    chk("stall_head_valid", 32'(head_valid), 32'd1);
    chk("stall_head_tag", 32'(head_tag), 32'd0);
    chk("stall_cmt_valid", 32'(cmt_valid), 32'd0);
    c0 = cyc;
    stall = 1'b0;
    expect_cmt(c0 + 32'd1, 2'b11, 2'b11, 5'd1, 6'd40, 5'd2, 6'd41, 1'b0, 1'b0, 32'h0);
    expect_cmt(c0 + 32'd2, 2'b11, 2'b11, 5'd3, 6'd42, 5'd4, 6'd43, 1'b0, 1'b0, 32'h0);
    repeat (3) step();
    chk("stall_drained", 32'(head_valid), 32'd0);
    chk("stall_head_tag_end", 32'(head_tag), 32'd4);

    // Reset lands on the edge where a mispredicted head would have flushed
    do_reset();
    enq(6'd0, 1'b1, 5'd31, 6'd1, 1'b1, 1'b0, 32'h40);
    for (int i = 1; i < 10; i++) begin
      enq(6'(i), 1'b1, 5'(i), 6'(i + 2), 1'b0, 1'b0, 32'(i * 4 + 32'h40));
    end
    cpl(1'b1, 6'd0, 1'b1, 32'h800, 1'b0, 6'd0, 1'b0, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midreset");
    repeat (3) step();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
